// File: rtl/mix_in_if.sv
// Command/write-port bundle of the MIX card-reader IN unit.
// slave is the mix_in side; master is the issuing controller/memory side.
interface mix_in_if;
  logic        start;
  logic [11:0] addressin;
  logic [11:0] addressout;
  logic        we;
  logic [30:0] out;
  logic        stop;
  logic        busy;

  modport slave  (input  start, addressin,
                  output addressout, we, out, stop, busy);
  modport master (output start, addressin,
                  input  addressout, we, out, stop, busy);
endinterface

// File: rtl/mix_in.sv
// MIX IN unit: receives ASCII over a UART line, converts it to MIX character
// codes and writes one block of BLOCKWORDS words starting at addressin.
module mix_in #(
  parameter int CLKDIV     = 217,
  parameter int BLOCKWORDS = 14
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rx,
  mix_in_if.slave  bus
);

  localparam int              IW      = $clog2(BLOCKWORDS + 1);
  localparam logic [11:0]     HALF_M1 = 12'(CLKDIV / 2 - 1);
  localparam logic [11:0]     FULL_M1 = 12'(CLKDIV - 1);
  localparam logic [IW-1:0]   LAST    = IW'(BLOCKWORDS - 1);

  typedef enum logic [2:0] {R_HUNT, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, PAD, DONE} state_t;

  rx_state_t   rstate;
  logic        rx_meta, rx_sync, rx_last;
  logic [11:0] rcnt;
  logic [2:0]  rbit;
  logic [7:0]  rshift;
  logic        byte_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_last    <= 1'b1;
      rstate     <= R_HUNT;
      rcnt       <= '0;
      rbit       <= '0;
      rshift     <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_last    <= rx_sync;
      byte_valid <= 1'b0;
      case (rstate)
        R_HUNT:
          if (rx_last && !rx_sync) begin
            rstate <= R_START;
            rcnt   <= HALF_M1;
          end
        R_START:
          if (rcnt != '0) rcnt <= rcnt - 12'd1;
          else if (!rx_sync) begin
            rstate <= R_DATA;
            rcnt   <= FULL_M1;
            rbit   <= '0;
          end else rstate <= R_HUNT;
        R_DATA:
          if (rcnt != '0) rcnt <= rcnt - 12'd1;
          else begin
            rshift <= {rx_sync, rshift[7:1]};
            rcnt   <= FULL_M1;
            rbit   <= rbit + 3'd1;
            if (rbit == 3'd7) rstate <= R_STOP;
          end
        R_STOP:
          if (rcnt != '0) rcnt <= rcnt - 12'd1;
          else if (rx_sync) begin
            byte_valid <= 1'b1;
            rstate     <= R_HUNT;
          end else rstate <= R_WAITHI;
        R_WAITHI:
          if (rx_sync) rstate <= R_HUNT;
        default: rstate <= R_HUNT;
      endcase
    end
  end

  logic [7:0] uc;
  logic [5:0] mix_code;
  logic       is_cr, is_lf;

  always_comb begin
    uc       = (rshift >= 8'h61 && rshift <= 8'h7A) ? rshift - 8'h20 : rshift;
    is_cr    = (rshift == 8'h0D);
    is_lf    = (rshift == 8'h0A);
    mix_code = '0;
    if (uc >= 8'h41 && uc <= 8'h49)      mix_code = 6'(uc - 8'h40);
    else if (uc >= 8'h4A && uc <= 8'h52) mix_code = 6'(uc - 8'h3F);
    else if (uc >= 8'h53 && uc <= 8'h5A) mix_code = 6'(uc - 8'h3D);
    else if (uc >= 8'h30 && uc <= 8'h39) mix_code = 6'(uc - 8'h12);
    else begin
      case (uc)
        8'h2E: mix_code = 6'd40;  // .
        8'h2C: mix_code = 6'd41;  // ,
        8'h28: mix_code = 6'd42;  // (
        8'h29: mix_code = 6'd43;  // )
        8'h2B: mix_code = 6'd44;  // +
        8'h2D: mix_code = 6'd45;  // -
        8'h2A: mix_code = 6'd46;  // *
        8'h2F: mix_code = 6'd47;  // /
        8'h3D: mix_code = 6'd48;  // =
        8'h24: mix_code = 6'd49;  // $
        8'h3C: mix_code = 6'd50;  // <
        8'h3E: mix_code = 6'd51;  // >
        8'h40: mix_code = 6'd52;  // @
        8'h3B: mix_code = 6'd53;  // ;
        8'h3A: mix_code = 6'd54;  // :
        8'h27: mix_code = 6'd55;  // '
        default: mix_code = '0;
      endcase
    end
  end

  state_t      state;
  logic [11:0] base;
  logic [IW-1:0] index;
  logic [2:0]  ccnt;
  logic [29:0] word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      index          <= '0;
      ccnt           <= '0;
      word           <= '0;
      bus.we         <= 1'b0;
      bus.stop       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.addressout <= '0;
      bus.out        <= '0;
    end else begin
      bus.we   <= 1'b0;
      bus.stop <= 1'b0;
      case (state)
        // The first IDLE cycle is the stop cycle, so busy drops one cycle later.
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start && !bus.busy) begin
            base     <= bus.addressin;
            index    <= '0;
            ccnt     <= '0;
            word     <= '0;
            bus.busy <= 1'b1;
            state    <= RECV;
          end
        end
        RECV:
          if (byte_valid && !is_lf) begin
            // Unfilled slots are already zero, so CR needs no explicit fill.
            if (is_cr) state <= PAD;
            else begin
              case (ccnt)
                3'd0:    word[29:24] <= mix_code;
                3'd1:    word[23:18] <= mix_code;
                3'd2:    word[17:12] <= mix_code;
                3'd3:    word[11:6]  <= mix_code;
                default: word[5:0]   <= mix_code;
              endcase
              ccnt <= ccnt + 3'd1;
              if (ccnt == 3'd4) state <= WRITE;
            end
          end
        WRITE, PAD: begin
          bus.we         <= 1'b1;
          bus.addressout <= base + 12'(index);
          bus.out        <= {1'b0, word};
          word           <= '0;
          ccnt           <= '0;
          index          <= index + IW'(1);
          if (index == LAST)       state <= DONE;
          else if (state == WRITE) state <= RECV;
        end
        DONE: begin
          bus.stop <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_in.sv
// Directed bench for mix_in: two instances (2- and 3-word blocks) share one
// UART line; written words are captured per instance and matched in order.
module tb_mix_in;
  localparam int CLKDIV = 16;

  logic clk, reset, rx;
  int   cyc = 0;
  int   n_checks = 0, n_err = 0;
  int   n_stop2 = 0, n_stop3 = 0, last_we2 = 0, last_we3 = 0;
  logic [42:0] wq2[$], wq3[$];

  mix_in_if mif2();
  mix_in_if mif3();

  mix_in #(.CLKDIV(CLKDIV), .BLOCKWORDS(2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx), .bus(mif2.slave));
  mix_in #(.CLKDIV(CLKDIV), .BLOCKWORDS(3)) dut3 (
    .clk(clk), .reset(reset), .rx(rx), .bus(mif3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mif2.we || mif2.stop) check("we_stop_excl2", 64'(mif2.we & mif2.stop), 0);
    if (mif2.we) begin wq2.push_back({mif2.addressout, mif2.out}); last_we2 = cyc; end
    if (mif2.stop) begin
      check("stop_latency2", 64'(cyc - last_we2), 1);
      check("busy_at_stop2", 64'(mif2.busy), 1);
      n_stop2++;
    end
  end

  always @(negedge clk) begin
    if (mif3.we || mif3.stop) check("we_stop_excl3", 64'(mif3.we & mif3.stop), 0);
    if (mif3.we) begin wq3.push_back({mif3.addressout, mif3.out}); last_we3 = cyc; end
    if (mif3.stop) begin
      check("stop_latency3", 64'(cyc - last_we3), 1);
      check("busy_at_stop3", 64'(mif3.busy), 1);
      n_stop3++;
    end
  end

  function automatic logic [30:0] mw(input int a, input int b, input int c, input int d, input int e);
    return {1'b0, 6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic good);
    rx = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rx = good;
    repeat (CLKDIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLKDIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic pulse_start(input int which, input logic [11:0] addr);
    if (which == 2) begin mif2.start = 1'b1; mif2.addressin = addr; end
    else            begin mif3.start = 1'b1; mif3.addressin = addr; end
    @(negedge clk);
    mif2.start = 1'b0;
    mif3.start = 1'b0;
  endtask

  task automatic wait_stop(input int which, input int target, input string tag);
    int n = 0;
    while (((which == 2) ? n_stop2 : n_stop3) < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'((which == 2) ? n_stop2 : n_stop3), 64'(target));
    @(negedge clk);
    check({tag, "_busy_low"}, 64'((which == 2) ? mif2.busy : mif3.busy), 0);
  endtask

  task automatic expect_word(input int which, input logic [11:0] addr, input logic [30:0] data,
                             input string tag);
    logic [42:0] e;
    int sz = (which == 2) ? wq2.size() : wq3.size();
    check({tag, "_present"}, 64'(sz > 0), 1);
    if (sz > 0) begin
      if (which == 2) e = wq2.pop_front();
      else            e = wq3.pop_front();
      check({tag, "_addr"}, 64'(e[42:31]), 64'(addr));
      check({tag, "_data"}, 64'(e[30:0]), 64'(data));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr2"}, 64'(mif2.addressout), 0);
    check({tag, "_out2"},  64'(mif2.out), 0);
    check({tag, "_ctl2"},  64'({mif2.we, mif2.stop, mif2.busy}), 0);
    check({tag, "_addr3"}, 64'(mif3.addressout), 0);
    check({tag, "_out3"},  64'(mif3.out), 0);
    check({tag, "_ctl3"},  64'({mif3.we, mif3.stop, mif3.busy}), 0);
  endtask

  initial begin
    int stops_before;
    rx = 1'b1;
    reset = 1'b1;
    mif2.start = 1'b0; mif2.addressin = '0;
    mif3.start = 1'b0; mif3.addressin = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // V6 + V1: byte before start dropped, busy start ignored, full block
    send_str("Q");
    pulse_start(2, 12'd100);
    check("v1_busy2", 64'(mif2.busy), 1);
    check("v1_idle3_busy", 64'(mif3.busy), 0);
    pulse_start(2, 12'd500);
    send_str("HELLO12345");
    wait_stop(2, 1, "v1_stop");
    expect_word(2, 12'd100, mw(8, 5, 13, 13, 16), "v1_w0");
    expect_word(2, 12'd101, mw(31, 32, 33, 34, 35), "v1_w1");
    check("v1_idle3_nowrite", 64'(wq3.size()), 0);

    // V2: CR padding on the 3-word instance
    pulse_start(3, 12'd0);
    send_str("AB");
    send_byte(8'h0D, 1'b1);
    wait_stop(3, 1, "v2_stop");
    expect_word(3, 12'd0, mw(1, 2, 0, 0, 0), "v2_w0");
    expect_word(3, 12'd1, 31'd0, "v2_w1");
    expect_word(3, 12'd2, 31'd0, "v2_w2");
    check("v2_idle2_nowrite", 64'(wq2.size()), 0);

    // V3: address wrap
    pulse_start(2, 12'd4095);
    send_str("ABCDEFGHIJ");
    wait_stop(2, 2, "v3_stop");
    expect_word(2, 12'd4095, mw(1, 2, 3, 4, 5), "v3_w0");
    expect_word(2, 12'd0, mw(6, 7, 8, 9, 11), "v3_w1");

    // V4 + lowercase + LF + punctuation/digit codes
    pulse_start(2, 12'd200);
    send_byte("Z", 1'b0);
    send_str("a");
    send_byte(8'h0A, 1'b1);
    send_str(".$@9");
    send_byte(8'h0D, 1'b1);
    wait_stop(2, 3, "v4_stop");
    expect_word(2, 12'd200, mw(1, 40, 49, 52, 39), "v4_w0");
    expect_word(2, 12'd201, 31'd0, "v4_w1");

    // V5: reset mid-word aborts, then a fresh block from slot 1
    stops_before = n_stop3;
    pulse_start(3, 12'd300);
    send_str("XYZ");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("v5_after_reset");
    check("v5_no_write", 64'(wq3.size()), 0);
    check("v5_no_stop", 64'(n_stop3), 64'(stops_before));
    pulse_start(3, 12'd400);
    send_str("K");
    send_byte(8'h0D, 1'b1);
    wait_stop(3, stops_before + 1, "v5_stop");
    expect_word(3, 12'd400, mw(12, 0, 0, 0, 0), "v5_w0");
    expect_word(3, 12'd401, 31'd0, "v5_w1");
    expect_word(3, 12'd402, 31'd0, "v5_w2");
    check("end_q2_empty", 64'(wq2.size()), 0);
    check("end_q3_empty", 64'(wq3.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mix_in.md
MIX_IN -- requirements
Module: mix_in

Interface
REQ-001 Parameters, one per line:
  - CLKDIV, 217, clocks per UART bit period (8N1); legal range 16..4095.
  - BLOCKWORDS, 14, words per IN block.
REQ-002 Ports, one per line:
  - clk  in  1  single clock; all logic on rising edge.
  - reset  in  1  synchronous, active-high reset.
  - rx  in  1  asynchronous UART serial input; idles high.
  - start  in  1  one-cycle IN command strobe.
  - addressin  in  12  block base address, sampled on start.
  - addressout  out  12  memory write address.
  - we  out  1  one-cycle memory write strobe.
  - out  out  31  word to write: {sign, 5 x 6-bit MIX chars}.
  - stop  out  1  one-cycle completion pulse.
  - busy  out  1  high from the cycle after start until the stop cycle, inclusive.

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-004 The receiver SHALL run continuously, including while idle:
  - it detects a falling edge of the synchronized rx;
  - it re-checks for low at CLKDIV/2 and returns to hunting if rx is high;
  - it then samples 8 data bits, LSB first, each CLKDIV clocks apart;
  - it then samples the stop bit.
REQ-005 A stop bit sampled low (framing error) SHALL discard the byte; the receiver then waits for rx high before hunting again.
REQ-006 Received bytes SHALL be discarded while the controller is IDLE.
REQ-007 Controller states SHALL be IDLE, RECV, WRITE, PAD and DONE.
REQ-008 IDLE: on start, latch base <= addressin, clear the word index and char count, and go to RECV.
REQ-009 ASCII-to-MIX conversion:
  - space -> 0; A-I -> 1-9; J-R -> 11-19; S-Z -> 22-29.
  - 0-9 -> 30-39.
  - . , ( ) + - * / = $ < > @ ; : ' -> 40-55, in that order.
  - lowercase letters map as uppercase.
  - all other bytes map to 0, except CR (0x0D) and LF (0x0A).
REQ-010 In RECV, each accepted character SHALL be placed into the next 6-bit slot of the assembly word:
  - slot 1 is bits 29:24 and slot 5 is bits 5:0;
  - the sign bit is 0 (+).
REQ-011 LF SHALL be ignored.
REQ-012 CR SHALL zero-fill the remaining slots of the current word, then go to PAD.
REQ-013 When slot 5 fills, the controller SHALL go to WRITE.
REQ-014 WRITE SHALL assert we for exactly one cycle:
  - addressout = (base + index) mod 4096;
  - out = the assembled word;
  - then increment index and clear the char count.
REQ-015 After WRITE, the controller SHALL go to DONE if index = BLOCKWORDS, else return to RECV.
REQ-016 PAD SHALL write the current partial word (if CR arrived mid-word, or a zero word if the char count is 0) and then all-zero words, one per cycle with we high, until index = BLOCKWORDS.
REQ-017 If CR arrives when the char count is 0 and index = BLOCKWORDS, this cannot occur; DONE is taken first.
REQ-018 DONE SHALL pulse stop for one cycle, then go to IDLE.
REQ-019 stop SHALL be asserted the cycle after the final we.
REQ-020 start SHALL be ignored while busy.
REQ-021 Address wrap-around past 4095 to 0 SHALL be silent.
REQ-022 A byte completing in the same cycle as start SHALL be discarded.
REQ-023 we and stop SHALL never be high in the same cycle.

Reset
REQ-024 On reset, the controller SHALL return to IDLE:
  - we=0, stop=0, busy=0;
  - addressout=0, out=0;
  - receiver returns to hunting; synchronizer flops set to 1.
REQ-025 Reset mid-block SHALL abort without any further write; a partial assembly word SHALL be discarded.
REQ-026 Outputs SHALL hold their reset values until the next start.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - V1, full block: BLOCKWORDS=2, start with addressin=100, send "HELLO12345" -> we at 100 with out=0x08_05_0D_0D_10 packed (H=8, E=5, L=13, L=13, O=16) and at 101 with 31,32,33,34,35; stop the cycle after the second we.
  - V2, CR padding: BLOCKWORDS=3, base 0, send "AB"+CR -> addr 0 gets {0,1,2,0,0,0}, addr 1 and 2 get 0; stop follows.
  - V3, wrap: base 4095, BLOCKWORDS=2, 10 chars -> writes at 4095 then 0.
  - V4, framing error: a byte with stop bit low is not stored; the next valid 'A' occupies slot 1.
  - V5, reset at mid-word (3 chars received) -> no we, no stop; a new start begins from slot 1 at the new addressin.
  - V6, idle/busy behaviour: bytes sent before start are dropped; a second start while busy is ignored (base unchanged); lowercase 'a' -> 1.
